key_schedule: RTL and testbench

KEY_SCHEDULE -- requirements
Module: key_schedule

---
 rtl/aes_pkg.sv | 18 +
 rtl/key_schedule_sbox.sv | 31 +++
 rtl/key_schedule.sv | 94 +++++++++
 tb/tb_key_schedule.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared constants, FSM state type and GF(2^8) helper for the AES-128 key schedule.
package aes_pkg;

  localparam int          NR_DEFAULT = 10;
  localparam logic [7:0]  RCON_INIT  = 8'h01;
  localparam logic [7:0]  XTIME_POLY = 8'h1B;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } ks_state_t;

  // Multiply by x in GF(2^8), reducing modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/key_schedule_sbox.sv
// AES forward S-box, purely combinational table lookup.
module sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Table lookup indexed by the input byte.
  always_comb begin
    out_byte = SBOX[in_byte];
  end

endmodule

// File: rtl/key_schedule.sv
// AES-128 key schedule: presents round keys 0..NR one at a time, stepping on next.
//
// state  | meaning
// IDLE   | no schedule running; valid/done low, round_key holds last value
// ACTIVE | round_key/round_num presented; next advances, start reloads
module key_schedule
  import aes_pkg::*;
#(
  parameter int NR = NR_DEFAULT
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         next,
  output logic [127:0] round_key,
  output logic [3:0]   round_num,
  output logic         valid,
  output logic         done
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  ks_state_t      state_q, state_d;
  logic [127:0]   round_key_q, round_key_d;
  logic [3:0]     round_num_q, round_num_d;
  logic [7:0]     rcon_q, rcon_d;

  logic [31:0]    w0, w1, w2, w3;
  logic [31:0]    rot_w3, sub_w3, t_word;
  logic [31:0]    w0_n, w1_n, w2_n, w3_n;
  logic [127:0]   expanded;

  assign {w0, w1, w2, w3} = round_key_q;
  assign rot_w3 = {w3[23:0], w3[31:24]};

  sbox u_sbox0 (.in_byte(rot_w3[31:24]), .out_byte(sub_w3[31:24]));
  sbox u_sbox1 (.in_byte(rot_w3[23:16]), .out_byte(sub_w3[23:16]));
  sbox u_sbox2 (.in_byte(rot_w3[15:8]),  .out_byte(sub_w3[15:8]));
  sbox u_sbox3 (.in_byte(rot_w3[7:0]),   .out_byte(sub_w3[7:0]));

  // Chained word expansion producing the next round key in one cycle.
  always_comb begin
    t_word   = sub_w3 ^ {rcon_q, 24'h0};
    w0_n     = w0 ^ t_word;
    w1_n     = w1 ^ w0_n;
    w2_n     = w2 ^ w1_n;
    w3_n     = w3 ^ w2_n;
    expanded = {w0_n, w1_n, w2_n, w3_n};
  end

  // Next-state logic: start reloads from either state and beats next.
  always_comb begin
    state_d     = state_q;
    round_key_d = round_key_q;
    round_num_d = round_num_q;
    rcon_d      = rcon_q;
    if (start) begin
      state_d     = ACTIVE;
      round_key_d = key_in;
      round_num_d = 4'd0;
      rcon_d      = RCON_INIT;
    end else if (state_q == ACTIVE && next) begin
      if (round_num_q == LAST_ROUND) begin
        state_d = IDLE;
      end else begin
        round_key_d = expanded;
        round_num_d = round_num_q + 4'd1;
        rcon_d      = xtime(rcon_q);
      end
    end
  end

  // Register update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      round_key_q <= 128'h0;
      round_num_q <= 4'd0;
      rcon_q      <= RCON_INIT;
    end else begin
      state_q     <= state_d;
      round_key_q <= round_key_d;
      round_num_q <= round_num_d;
      rcon_q      <= rcon_d;
    end
  end

  assign round_key = round_key_q;
  assign round_num = round_num_q;
  assign valid     = (state_q == ACTIVE);
  assign done      = valid & (round_num_q == LAST_ROUND);

endmodule

// File: tb/tb_key_schedule.sv
// Self-checking bench for key_schedule using FIPS-197 round-key vectors.
module tb_key_schedule;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic [127:0] key_in;
  logic         next;
  logic [127:0] round_key;
  logic [3:0]   round_num;
  logic         valid;
  logic         done;

  int vectors;
  int miscompares;

  typedef struct {
    logic [3:0]   rn;
    logic [127:0] key;
    logic         dn;
  } exp_t;

  exp_t sb_q[$];

  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY_B_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] PLAIN = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] ARK_A = 128'h193de3bea0f4e22b9ac68d2ae9f84808;

  logic [127:0] rk_a [11];

  key_schedule #(.NR(10)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .key_in(key_in),
    .next(next), .round_key(round_key), .round_num(round_num),
    .valid(valid), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b1; next = 1'b1; key_in = KEY_A;
    tick(); tick();
    start = 1'b0; next = 1'b0; reset_n = 1'b1;
    vectors++;
    if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %0b want 0", valid); end
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %0b want 0", done); end
    vectors++;
    if (round_num !== 4'd0) begin miscompares++; $display("FAIL reset_round_num got %0d want 0", round_num); end
    vectors++;
    if (round_key !== 128'h0) begin miscompares++; $display("FAIL reset_round_key got %h want 0", round_key); end
  endtask

  task automatic test_start();
    exp_t e;
    key_in = KEY_A; start = 1'b1;
    sb_q.push_back('{rn: 4'd0, key: KEY_A, dn: 1'b0});
    tick();
    start = 1'b0; key_in = '0;
    e = sb_q.pop_front();
    vectors++;
    if (valid !== 1'b1 || round_num !== e.rn || round_key !== e.key || done !== e.dn) begin
      miscompares++;
      $display("FAIL start_load got v=%0b rn=%0d key=%h d=%0b want v=1 rn=%0d key=%h d=%0b",
               valid, round_num, round_key, done, e.rn, e.key, e.dn);
    end
    vectors++;
    if ((round_key ^ PLAIN) !== ARK_A) begin
      miscompares++;
      $display("FAIL add_round_key got %h want %h", round_key ^ PLAIN, ARK_A);
    end
  endtask

  task automatic test_next_pulse();
    exp_t e;
    for (int r = 1; r <= 2; r++) begin
      next = 1'b1;
      sb_q.push_back('{rn: 4'(r), key: rk_a[r], dn: 1'b0});
      tick();
      next = 1'b0;
      e = sb_q.pop_front();
      vectors++;
      if (valid !== 1'b1 || round_num !== e.rn || round_key !== e.key || done !== e.dn) begin
        miscompares++;
        $display("FAIL next_pulse got rn=%0d key=%h want rn=%0d key=%h", round_num, round_key, e.rn, e.key);
      end
    end
    // Without next everything must hold for several cycles.
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back('{rn: 4'd2, key: rk_a[2], dn: 1'b0});
      tick();
      e = sb_q.pop_front();
      vectors++;
      if (valid !== 1'b1 || round_num !== e.rn || round_key !== e.key) begin
        miscompares++;
        $display("FAIL hold got rn=%0d key=%h want rn=%0d key=%h", round_num, round_key, e.rn, e.key);
      end
    end
  endtask

  task automatic test_full_schedule();
    exp_t e;
    key_in = KEY_A; start = 1'b1;
    tick();
    start = 1'b0;
    next = 1'b1;
    for (int r = 1; r <= 10; r++) begin
      sb_q.push_back('{rn: 4'(r), key: rk_a[r], dn: (r == 10)});
      tick();
      if (r == 10) next = 1'b0;
      e = sb_q.pop_front();
      vectors++;
      if (valid !== 1'b1 || round_num !== e.rn || round_key !== e.key || done !== e.dn) begin
        miscompares++;
        $display("FAIL full_round%0d got rn=%0d key=%h d=%0b want rn=%0d key=%h d=%0b",
                 r, round_num, round_key, done, e.rn, e.key, e.dn);
      end
    end
    // Last key is presented indefinitely until next.
    tick();
    vectors++;
    if (done !== 1'b1 || round_num !== 4'd10) begin
      miscompares++;
      $display("FAIL final_hold got rn=%0d d=%0b want rn=10 d=1", round_num, done);
    end
    next = 1'b1;
    tick();
    next = 1'b0;
    vectors++;
    if (valid !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL end_to_idle got v=%0b d=%0b want v=0 d=0", valid, done);
    end
    vectors++;
    if (round_key !== rk_a[10]) begin
      miscompares++;
      $display("FAIL end_key_hold got %h want %h", round_key, rk_a[10]);
    end
    // next in IDLE is ignored.
    next = 1'b1;
    tick(); tick();
    next = 1'b0;
    vectors++;
    if (valid !== 1'b0 || round_key !== rk_a[10] || round_num !== 4'd10) begin
      miscompares++;
      $display("FAIL idle_next got v=%0b rn=%0d key=%h want v=0 rn=10 key=%h", valid, round_num, round_key, rk_a[10]);
    end
  endtask

  task automatic test_restart();
    exp_t e;
    key_in = KEY_A; start = 1'b1;
    tick();
    start = 1'b0; next = 1'b1;
    for (int r = 1; r <= 5; r++) tick();
    vectors++;
    if (round_num !== 4'd5 || round_key !== rk_a[5]) begin
      miscompares++;
      $display("FAIL restart_pre got rn=%0d key=%h want rn=5 key=%h", round_num, round_key, rk_a[5]);
    end
    start = 1'b1; key_in = KEY_B;
    sb_q.push_back('{rn: 4'd0, key: KEY_B, dn: 1'b0});
    tick();
    start = 1'b0; next = 1'b0; key_in = '0;
    e = sb_q.pop_front();
    vectors++;
    if (valid !== 1'b1 || round_num !== e.rn || round_key !== e.key) begin
      miscompares++;
      $display("FAIL restart_load got rn=%0d key=%h want rn=%0d key=%h", round_num, round_key, e.rn, e.key);
    end
    next = 1'b1;
    for (int r = 1; r <= 10; r++) tick();
    next = 1'b0;
    sb_q.push_back('{rn: 4'd10, key: KEY_B_R10, dn: 1'b1});
    e = sb_q.pop_front();
    vectors++;
    if (valid !== 1'b1 || round_num !== e.rn || round_key !== e.key || done !== e.dn) begin
      miscompares++;
      $display("FAIL restart_final got rn=%0d key=%h d=%0b want rn=%0d key=%h d=1",
               round_num, round_key, done, e.rn, e.key);
    end
  endtask

  task automatic test_reset_mid();
    key_in = KEY_A; start = 1'b1;
    tick();
    start = 1'b0; next = 1'b1;
    for (int r = 1; r <= 3; r++) tick();
    next = 1'b0;
    vectors++;
    if (round_num !== 4'd3 || round_key !== rk_a[3]) begin
      miscompares++;
      $display("FAIL mid_pre got rn=%0d key=%h want rn=3 key=%h", round_num, round_key, rk_a[3]);
    end
    reset_n = 1'b0; next = 1'b1;
    tick();
    reset_n = 1'b1; next = 1'b0;
    vectors++;
    if (valid !== 1'b0 || round_num !== 4'd0 || round_key !== 128'h0) begin
      miscompares++;
      $display("FAIL mid_reset got v=%0b rn=%0d key=%h want v=0 rn=0 key=0", valid, round_num, round_key);
    end
    for (int i = 0; i < 3; i++) begin
      next = 1'b1; tick(); next = 1'b0; tick();
    end
    vectors++;
    if (valid !== 1'b0 || round_num !== 4'd0 || round_key !== 128'h0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset got v=%0b rn=%0d key=%h want v=0 rn=0 key=0", valid, round_num, round_key);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rk_a[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rk_a[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk_a[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk_a[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk_a[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk_a[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk_a[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk_a[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk_a[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk_a[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk_a[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    reset_n = 1'b1; start = 1'b0; next = 1'b0; key_in = '0;
    #2;
    test_reset();
    test_start();
    test_next_pulse();
    test_full_schedule();
    test_restart();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
